// File: rtl/axis_pixel_unpacker_if.sv
// Stream interfaces around the pixel unpacker: packed AXI-Stream words in,
// tagged single pixels out.
interface axis_word_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

interface pix_stream_if #(
  parameter int PIX_WIDTH = 8,
  parameter int COL_WIDTH = 6,
  parameter int ROW_WIDTH = 6
);
  logic                 valid;
  logic                 ready;
  logic [PIX_WIDTH-1:0] data;
  logic [COL_WIDTH-1:0] col;
  logic [ROW_WIDTH-1:0] row;
  logic                 sof;
  logic                 eol;
  logic                 eof;

  modport master (output valid, data, col, row, sof, eol, eof, input ready);
  modport slave  (input valid, data, col, row, sof, eol, eof, output ready);
endinterface

// File: rtl/axis_pixel_unpacker.sv
// Splits 32-bit AXI-Stream words into one tagged pixel per cycle and checks
// TLAST framing against the configured frame size.
module axis_pixel_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int PIX_WIDTH  = 8,
  parameter int IMG_WIDTH  = 48,
  parameter int IMG_HEIGHT = 48
) (
  input  logic          clk,
  input  logic          rst,
  axis_word_if.slave    s_axis,
  pix_stream_if.master  m_pix,
  output logic          err_early_last,
  output logic          err_missing_last,
  input  logic          err_clr,
  output logic          busy
);

  localparam int FRAME_WORDS = IMG_WIDTH * IMG_HEIGHT / 4;
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int WCNT_W = $clog2(FRAME_WORDS);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FRAME_WORDS - 1);

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  word_full_q, word_full_d;
  logic [1:0]            lane_q, lane_d;
  logic                  word_eof_q, word_eof_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  early_q, early_d;
  logic                  missing_q, missing_d;

  logic in_ready, accept, xfer, last_lane, set_early, set_missing;
  logic unused_tstrb;
  logic [PIX_WIDTH-1:0] lanes [4];

  assign unused_tstrb = ^s_axis.tstrb;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lanes[i] = word_q[DATA_WIDTH-1-i*PIX_WIDTH -: PIX_WIDTH];
  end

  assign last_lane   = (lane_q == 2'd3);
  assign xfer        = word_full_q && m_pix.ready;
  assign in_ready    = !word_full_q || (last_lane && xfer);
  assign accept      = s_axis.tvalid && in_ready;
  assign set_early   = accept && s_axis.tlast && (wcnt_q != WCNT_LAST);
  assign set_missing = accept && !s_axis.tlast && (wcnt_q == WCNT_LAST);

  // A word that closes a frame (by TLAST or by count) carries word_eof so its
  // lane 3 marks eof and returns the pixel position to (0,0).
  always_comb begin
    word_d      = word_q;
    word_full_d = word_full_q;
    lane_d      = lane_q;
    word_eof_d  = word_eof_q;
    col_d       = col_q;
    row_d       = row_q;
    wcnt_d      = wcnt_q;
    if (xfer) begin
      lane_d = lane_q + 2'd1;
      if (last_lane) word_full_d = 1'b0;
      if (last_lane && word_eof_q) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (accept) begin
      word_d      = s_axis.tdata;
      word_full_d = 1'b1;
      lane_d      = 2'd0;
      word_eof_d  = s_axis.tlast || (wcnt_q == WCNT_LAST);
      wcnt_d      = word_eof_d ? '0 : wcnt_q + 1'b1;
    end
    early_d   = set_early   ? 1'b1 : (err_clr ? 1'b0 : early_q);
    missing_d = set_missing ? 1'b1 : (err_clr ? 1'b0 : missing_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q      <= '0;
      word_full_q <= 1'b0;
      lane_q      <= 2'd0;
      word_eof_q  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      wcnt_q      <= '0;
      early_q     <= 1'b0;
      missing_q   <= 1'b0;
    end else begin
      word_q      <= word_d;
      word_full_q <= word_full_d;
      lane_q      <= lane_d;
      word_eof_q  <= word_eof_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wcnt_q      <= wcnt_d;
      early_q     <= early_d;
      missing_q   <= missing_d;
    end
  end

  // Handshake outputs are masked during reset so nothing moves in that cycle.
  assign s_axis.tready    = in_ready && !rst;
  assign m_pix.valid      = word_full_q && !rst;
  assign m_pix.data       = lanes[lane_q];
  assign m_pix.col        = col_q;
  assign m_pix.row        = row_q;
  assign m_pix.sof        = (col_q == '0) && (row_q == '0);
  assign m_pix.eol        = (col_q == COL_LAST);
  assign m_pix.eof        = last_lane && word_eof_q;
  assign err_early_last   = early_q;
  assign err_missing_last = missing_q;
  assign busy             = word_full_q || (wcnt_q != '0);

endmodule
